mult_issue_ctrl: RTL
====================

Name: mult_issue_ctrl

Overview:
- Initiator side of the multiplier interface. Accepts multiply requests from the execute stage over a valid/ready handshake.
- Drives oper_a/oper_b/operation/enable_mult to the radix-8 multiplier and holds them stable until mult_finish.
- Captures mult_o and returns it over a valid/ready response channel. Asserts a pipeline stall while busy.
- Holds a one-entry result cache so back-to-back identical requests complete without reissuing, plus a timeout watchdog.

Parameters:
- LENGTH, 32, operand/result width.
- TIMEOUT_CYCLES, 64, max cycles in WAIT before the error response; must be >= 2.
- CACHE_EN, 1, 1 enables the one-entry result cache, 0 disables it (every request issues).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept.
- req_a  in  LENGTH  operand A, signed.
- req_b  in  LENGTH  operand B, signed.
- req_op  in  1  result half select; passed to operation.
- flush  in  1  abort in-flight op and invalidate cache.
- oper_a  out  LENGTH  to multiplier.
- oper_b  out  LENGTH  to multiplier.
- operation  out  1  to multiplier.
- enable_mult  out  1  multiplier enable.
- mult_o  in  LENGTH  multiplier result.
- mult_finish  in  1  multiplier done.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts.
- rsp_data  out  LENGTH  result.
- rsp_err  out  1  timeout occurred.
- stall  out  1  pipeline stall.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State -> IDLE. Cache invalid, timeout counter 0.
  - All outputs 0, except req_ready=1 once rst_n=1.
  - Reset mid-operation drops enable_mult on the next edge and discards the result.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, stall=0, enable_mult=0.
  - On accept (req_valid & req_ready) at edge T: latch req_a/req_b/req_op.
  - Cache hit (CACHE_EN, cache valid, a/b/op all equal to cached values): -> RESP with cached result, rsp_err=0. rsp_valid=1 in cycle T+1. Multiplier untouched.
  - Miss: -> WAIT. Counter cleared.
- WAIT:
  - enable_mult=1; oper_a/oper_b/operation hold latched values; req_ready=0; stall=1.
  - Counter increments each cycle.
  - mult_finish=1 at an edge: capture mult_o into rsp_data and cache (a, b, op, result). Cache valid=1, rsp_err=0. -> RESP; enable_mult=0 the next cycle.
  - Counter reaching TIMEOUT_CYCLES without finish: rsp_data=0, rsp_err=1. -> RESP. Cache not updated.
  - Finish and timeout in the same cycle: finish wins.
- RESP:
  - rsp_valid=1; rsp_data/rsp_err stable until accepted. stall=1 and req_ready=0 while rsp_valid & !rsp_ready.
  - On rsp_ready: -> IDLE. req_ready=1 the next cycle. No same-cycle accept of a new request.
- Latency:
  - Hit: response 1 cycle after accept.
  - Miss: response 1 cycle after the mult_finish edge. Minimum 2 cycles when finish is asserted in the first WAIT cycle.
- flush (any state, highest priority after reset):
  - Next state IDLE; enable_mult=0 and rsp_valid=0 next cycle; cache invalidated; in-flight result discarded.
  - A mult_finish arriving in the flush cycle or later is ignored.
- Outputs oper_a/oper_b/operation hold their last values outside WAIT. enable_mult alone qualifies them.
- mult_finish outside WAIT is ignored.
- Arithmetic: no computation; data passes through at full LENGTH width. Cache compare is exact equality on all LENGTH bits plus op.

Test Plan:
- Basic miss: req a=7, b=6, op=0; multiplier returns finish with mult_o=42 in 3rd WAIT cycle -> enable_mult high 3 cycles; rsp_valid with rsp_data=42, rsp_err=0; stall high throughout.
- Cache hit: after the above, req a=7, b=6, op=0 -> rsp_valid=1 next cycle with 42; enable_mult stays 0. Then a=7, b=6, op=1 -> miss, issues.
- Signed high word: a=-3 (0xFFFFFFFD), b=5, op=1, model returns 0xFFFFFFFF -> rsp_data=0xFFFFFFFF; oper_a=0xFFFFFFFD stable every WAIT cycle.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data stable, req_ready=0, stall=1 throughout; accept on cycle 6 -> req_ready=1 the next cycle.
- Timeout: TIMEOUT_CYCLES=8, finish never asserted -> rsp_err=1, rsp_data=0 after 8 WAIT cycles. Repeat same operands -> miss (cache not filled).
- Flush/reset: flush in 2nd WAIT cycle, then late finish -> no rsp_valid; enable_mult=0 next cycle; following same-operand request misses. rst_n=0 mid-WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mult_issue_ctrl_if.sv
// mult_issue_ctrl_if: request, response and multiplier-side signals for
// mult_issue_ctrl. master = controller view, slave = environment view.
interface mult_issue_ctrl_if #(
  parameter int LENGTH = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [LENGTH-1:0] req_a;
  logic [LENGTH-1:0] req_b;
  logic              req_op;
  logic              flush;
  logic [LENGTH-1:0] oper_a;
  logic [LENGTH-1:0] oper_b;
  logic              operation;
  logic              enable_mult;
  logic [LENGTH-1:0] mult_o;
  logic              mult_finish;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [LENGTH-1:0] rsp_data;
  logic              rsp_err;
  logic              stall;

  modport master (
    input  req_valid, req_a, req_b, req_op, flush,
    input  mult_o, mult_finish, rsp_ready,
    output req_ready, oper_a, oper_b, operation,
    output enable_mult, rsp_valid, rsp_data,
    output rsp_err, stall
  );

  modport slave (
    output req_valid, req_a, req_b, req_op, flush,
    output mult_o, mult_finish, rsp_ready,
    input  req_ready, oper_a, oper_b, operation,
    input  enable_mult, rsp_valid, rsp_data,
    input  rsp_err, stall
  );
endinterface

// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: issues multiply requests to the radix-8 multiplier,
// holds operands until finish, returns result with 1-entry cache + watchdog.
// Ports: clk, rst_n (sync, active low), bus (master modport):
//   req_* in, rsp_* out, oper_*/operation/enable_mult out, mult_* in,
//   flush in, stall out.
module mult_issue_ctrl #(
  parameter int LENGTH         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CACHE_EN       = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mult_issue_ctrl_if.master  bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic [LENGTH-1:0] r_oper_a;
  logic [LENGTH-1:0] r_oper_b;
  logic              r_oper_op;
  logic [LENGTH-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic              r_c_vld;
  logic [LENGTH-1:0] r_c_a;
  logic [LENGTH-1:0] r_c_b;
  logic              r_c_op;
  logic [LENGTH-1:0] r_c_res;

  logic w_rdy;
  logic w_match;
  logic w_accept;
  logic w_hit;
  logic w_miss;
  logic w_done;
  logic w_tmo;

  // Masked during reset and flush so a
  // request is never taken and then dropped.
  assign w_rdy = rst_n & ~bus.flush &
                 (r_state == S_IDLE);

  assign w_match = (CACHE_EN != 0) & r_c_vld &
                   (bus.req_a == r_c_a) &
                   (bus.req_b == r_c_b) &
                   (bus.req_op == r_c_op);

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_hit    = 1'b0;
    w_miss   = 1'b0;
    w_done   = 1'b0;
    w_tmo    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_accept = bus.req_valid & w_rdy;
        w_hit    = w_accept & w_match;
        w_miss   = w_accept & ~w_match;
        if (w_hit)  w_next = S_RESP;
        if (w_miss) w_next = S_WAIT;
      end
      S_WAIT: begin
        // Finish beats a same-cycle timeout.
        if (bus.mult_finish) begin
          w_done = 1'b1;
          w_next = S_RESP;
        end else if (r_cnt == CNT_MAX) begin
          w_tmo  = 1'b1;
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (bus.flush) begin
      w_next = S_IDLE;
      w_done = 1'b0;
      w_tmo  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_miss) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_oper_a   <= '0;
      r_oper_b   <= '0;
      r_oper_op  <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_c_vld    <= 1'b0;
      r_c_a      <= '0;
      r_c_b      <= '0;
      r_c_op     <= 1'b0;
      r_c_res    <= '0;
    end else if (bus.flush) begin
      r_c_vld <= 1'b0;
    end else begin
      if (w_miss) begin
        r_oper_a  <= bus.req_a;
        r_oper_b  <= bus.req_b;
        r_oper_op <= bus.req_op;
      end
      if (w_hit) begin
        r_rsp_data <= r_c_res;
        r_rsp_err  <= 1'b0;
      end
      if (w_done) begin
        r_rsp_data <= bus.mult_o;
        r_rsp_err  <= 1'b0;
        r_c_vld    <= 1'b1;
        r_c_a      <= r_oper_a;
        r_c_b      <= r_oper_b;
        r_c_op     <= r_oper_op;
        r_c_res    <= bus.mult_o;
      end
      if (w_tmo) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
      end
    end
  end

  assign bus.req_ready   = w_rdy;
  assign bus.oper_a      = r_oper_a;
  assign bus.oper_b      = r_oper_b;
  assign bus.operation   = r_oper_op;
  assign bus.enable_mult = (r_state == S_WAIT);
  assign bus.rsp_valid   = (r_state == S_RESP);
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.stall       = (r_state == S_WAIT) |
                           ((r_state == S_RESP) &
                            ~bus.rsp_ready);

endmodule
